// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW:0]     in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one shift stage per amount bit plus an overflow
// stage, each followed by a register slot, with valid/ready on both ends.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  pipelined_barrel_shifter_if.slave  bus
);
  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned NSLOT = SHW + 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW:0]     amt;
    logic [1:0]       mode;
    logic             sign;
  } slot_t;

  logic [NSLOT-1:0] valid_q, valid_d;
  slot_t            slot_q [NSLOT];
  slot_t            slot_d [NSLOT];
  slot_t            src_c  [NSLOT];
  logic [NSLOT-1:0] src_v_c;
  logic [NSLOT-1:0] load_c;

  // Conditional shift by 2^k for stage k.
  function automatic logic [WIDTH-1:0] stage_shift(input slot_t s, input int unsigned k);
    logic [2*WIDTH-1:0] ext;
    int unsigned        sh;
    logic [WIDTH-1:0]   res;
    sh  = 32'(1) << k;
    ext = '0;
    res = s.data;
    if (s.amt[k]) begin
      case (s.mode)
        MODE_SLL: res = s.data << sh;
        MODE_SRL: res = s.data >> sh;
        MODE_SRA: begin
          ext = {{WIDTH{s.sign}}, s.data} >> sh;
          res = ext[WIDTH-1:0];
        end
        default: begin
          ext = {s.data, s.data} << sh;
          res = ext[2*WIDTH-1:WIDTH];
        end
      endcase
    end
    return res;
  endfunction

  // Amounts of WIDTH or more; rotate keeps amt mod WIDTH.
  function automatic logic [WIDTH-1:0] overflow_fix(input slot_t s);
    logic [WIDTH-1:0] res;
    res = s.data;
    if (s.amt[SHW]) begin
      case (s.mode)
        MODE_SLL, MODE_SRL: res = '0;
        MODE_SRA:           res = {WIDTH{s.sign}};
        default:            res = s.data;
      endcase
    end
    return res;
  endfunction

  // A slot loads when empty or when its content moves on; bubbles collapse.
  always_comb begin
    logic take;
    load_c = '0;
    take   = bus.out_ready;
    for (int k = int'(NSLOT) - 1; k >= 0; k--) begin
      load_c[k] = !valid_q[k] || take;
      take      = load_c[k];
    end
  end

  always_comb begin
    src_c[0].data = bus.in_data;
    src_c[0].amt  = bus.in_amt;
    src_c[0].mode = bus.in_mode;
    src_c[0].sign = bus.in_data[WIDTH-1];
    src_v_c[0]    = bus.in_valid;
    for (int unsigned k = 1; k < NSLOT; k++) begin
      src_c[k]   = slot_q[k-1];
      src_v_c[k] = valid_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      slot_d[k] = slot_q[k];
    end
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (load_c[k]) begin
        valid_d[k] = src_v_c[k];
        // Data only updates on a real operand so the output holds after emit.
        if (src_v_c[k]) begin
          slot_d[k]      = src_c[k];
          slot_d[k].data = (k == NSLOT - 1) ? overflow_fix(src_c[k])
                                            : stage_shift(src_c[k], k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NSLOT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < NSLOT; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign bus.in_ready  = load_c[0];
  assign bus.out_valid = valid_q[NSLOT-1];
  assign bus.out_data  = slot_q[NSLOT-1].data;
  assign bus.out_zero  = (slot_q[NSLOT-1].data == '0);
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed modes, streaming at three
// widths, backpressure, random handshakes and mid-flight reset.
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(8))  b8 ();
  pipelined_barrel_shifter_if #(.WIDTH(16)) b16 ();
  pipelined_barrel_shifter_if #(.WIDTH(32)) b32 ();

  pipelined_barrel_shifter #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  pipelined_barrel_shifter #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  pipelined_barrel_shifter #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] q8[$];
  logic [63:0] q16[$];
  logic [63:0] q32[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: shift semantics from plain arithmetic on a w-bit value.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int amt,
                                            input int mode, input int w);
    logic [63:0] mask;
    logic        sgn;
    int          a;
    mask = (64'd1 << w) - 64'd1;
    sgn  = d[w-1];
    a    = amt;
    if (a >= w) begin
      if (mode == 0 || mode == 1) return 64'd0;
      if (mode == 2) return sgn ? mask : 64'd0;
      a = a % w;
    end
    case (mode)
      0:       return (d << a) & mask;
      1:       return d >> a;
      2:       return (d >> a) | (sgn ? (mask & ~(mask >> a)) : 64'd0);
      default: return ((d << a) | (d >> (w - a))) & mask;
    endcase
  endfunction

  // Scoreboards: head must be on out_data whenever out_valid is high.
  always @(negedge clk) if (rst_n) begin
    if (b8.out_valid) begin
      if (q8.size() == 0) check("w8_unexpected_out", 64'(b8.out_valid), 64'd0);
      else begin
        check("w8_data", 64'(b8.out_data), q8[0]);
        check("w8_zero", 64'(b8.out_zero), 64'(q8[0] == 64'd0));
        if (b8.out_ready) void'(q8.pop_front());
      end
    end
    if (b8.in_valid && b8.in_ready)
      q8.push_back(ref_shift(64'(b8.in_data), int'(b8.in_amt), int'(b8.in_mode), 8));
  end

  always @(negedge clk) if (rst_n) begin
    if (b16.out_valid) begin
      if (q16.size() == 0) check("w16_unexpected_out", 64'(b16.out_valid), 64'd0);
      else begin
        check("w16_data", 64'(b16.out_data), q16[0]);
        if (b16.out_ready) void'(q16.pop_front());
      end
    end
    if (b16.in_valid && b16.in_ready)
      q16.push_back(ref_shift(64'(b16.in_data), int'(b16.in_amt), int'(b16.in_mode), 16));
  end

  always @(negedge clk) if (rst_n) begin
    if (b32.out_valid) begin
      if (q32.size() == 0) check("w32_unexpected_out", 64'(b32.out_valid), 64'd0);
      else begin
        check("w32_data", 64'(b32.out_data), q32[0]);
        if (b32.out_ready) void'(q32.pop_front());
      end
    end
    if (b32.in_valid && b32.in_ready)
      q32.push_back(ref_shift(64'(b32.in_data), int'(b32.in_amt), int'(b32.in_mode), 32));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One operand into an empty pipe; result must appear on the 4th edge.
  task automatic single8(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m,
                         input logic [7:0] exp, input string tag);
    b8.in_data   = d;
    b8.in_amt    = a;
    b8.in_mode   = m;
    b8.in_valid  = 1'b1;
    b8.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(b8.in_ready), 64'd1);
    next_cycle();
    b8.in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check({tag, "_latency"}, 64'(b8.out_valid), 64'(e == 4));
      if (e < 4) next_cycle();
    end
    check({tag, "_data"}, 64'(b8.out_data), 64'(exp));
    check({tag, "_zero"}, 64'(b8.out_zero), 64'(exp == 8'h00));
    next_cycle();
  endtask

  initial begin
    int acc;
    logic [7:0] dval;
    rst_n = 1'b0;
    b8.in_valid = 1'b0;  b8.in_data = '0;  b8.in_amt = '0;  b8.in_mode = '0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_amt = '0; b16.in_mode = '0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_amt = '0; b32.in_mode = '0; b32.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(b8.out_valid), 64'd0);
    check("rst_out_data",  64'(b8.out_data),  64'd0);
    check("rst_out_zero",  64'(b8.out_zero),  64'd1);
    @(posedge clk); #3; rst_n = 1'b1;
    next_cycle();
    check("post_rst_in_ready", 64'(b8.in_ready), 64'd1);

    // Directed modes, overflow amounts, identity
    single8(8'h96, 4'd3,  2'd0, 8'hB0, "sll3");
    single8(8'h96, 4'd2,  2'd1, 8'h25, "srl2");
    single8(8'h96, 4'd2,  2'd2, 8'hE5, "sra2");
    single8(8'h96, 4'd3,  2'd3, 8'hB4, "rol3");
    single8(8'h96, 4'd9,  2'd0, 8'h00, "sll9");
    single8(8'h96, 4'd8,  2'd1, 8'h00, "srl8");
    single8(8'h96, 4'd8,  2'd2, 8'hFF, "sra8");
    single8(8'h96, 4'd11, 2'd3, 8'hB4, "rol11");
    single8(8'h76, 4'd12, 2'd2, 8'h00, "sra12_pos");
    for (int m = 0; m < 4; m++) single8(8'h96, 4'd0, 2'(m), 8'h96, "amt0");

    // Streaming at all three widths, 16 back-to-back operands
    for (int c = 0; c < 24; c++) begin
      b8.in_valid  = (c < 16);
      b16.in_valid = (c < 16);
      b32.in_valid = (c < 16);
      b8.in_data  = 8'($urandom);  b8.in_amt  = 4'($urandom_range(0, 15)); b8.in_mode  = 2'($urandom);
      b16.in_data = 16'($urandom); b16.in_amt = 5'($urandom_range(0, 31)); b16.in_mode = 2'($urandom);
      b32.in_data = 32'($urandom); b32.in_amt = 6'($urandom_range(0, 63)); b32.in_mode = 2'($urandom);
      @(negedge clk);
      if (c < 16) begin
        check("stream_w8_in_ready",  64'(b8.in_ready),  64'd1);
        check("stream_w16_in_ready", 64'(b16.in_ready), 64'd1);
        check("stream_w32_in_ready", 64'(b32.in_ready), 64'd1);
      end
      check("stream_w8_out_valid",  64'(b8.out_valid),  64'(c >= 4 && c < 20));
      check("stream_w16_out_valid", 64'(b16.out_valid), 64'(c >= 5 && c < 21));
      check("stream_w32_out_valid", 64'(b32.out_valid), 64'(c >= 6 && c < 22));
      next_cycle();
    end
    check("stream_w8_drained",  64'(q8.size()),  64'd0);
    check("stream_w16_drained", 64'(q16.size()), 64'd0);
    check("stream_w32_drained", 64'(q32.size()), 64'd0);

    // Backpressure: capacity is four operands
    b8.out_ready = 1'b0;
    acc  = 0;
    dval = 8'h10;
    for (int c = 0; c < 10; c++) begin
      b8.in_valid = 1'b1;
      b8.in_data  = dval;
      b8.in_amt   = 4'($urandom_range(0, 15));
      b8.in_mode  = 2'($urandom);
      @(negedge clk);
      check("bp_in_ready", 64'(b8.in_ready), 64'(c < 4));
      if (b8.in_ready) begin
        acc++;
        dval++;
      end
      next_cycle();
    end
    check("bp_accepts", 64'(acc), 64'd4);
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    repeat (8) next_cycle();
    check("bp_drained", 64'(q8.size()), 64'd0);

    // Random handshake toggling
    for (int c = 0; c < 300; c++) begin
      b8.in_valid  = 1'($urandom_range(0, 1));
      b8.out_ready = ($urandom_range(0, 3) != 0);
      b8.in_data   = 8'($urandom);
      b8.in_amt    = 4'($urandom_range(0, 15));
      b8.in_mode   = 2'($urandom);
      next_cycle();
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    repeat (8) next_cycle();
    check("rand_drained", 64'(q8.size()), 64'd0);

    // Reset with three operands in flight
    b8.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b8.in_valid = 1'b1;
      b8.in_data  = 8'hA5 + 8'(c);
      b8.in_amt   = 4'd1;
      b8.in_mode  = 2'd3;
      next_cycle();
    end
    b8.in_valid = 1'b0;
    next_cycle();
    check("pre_rst_out_valid", 64'(b8.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    q8.delete();
    #1;
    check("mid_rst_out_valid", 64'(b8.out_valid), 64'd0);
    check("mid_rst_out_data",  64'(b8.out_data),  64'd0);
    check("mid_rst_out_zero",  64'(b8.out_zero),  64'd1);
    @(posedge clk); #3; rst_n = 1'b1;
    b8.out_ready = 1'b1;
    next_cycle();
    check("post_mid_rst_in_ready", 64'(b8.in_ready), 64'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_mid_rst_no_old", 64'(b8.out_valid), 64'd0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
